dm_access_ctrl: RTL and testbench

//   Initiator side of the DM port. Converts CPU load/store requests (byte, half, word;

---
 rtl/dm_access_ctrl_pkg.sv | 30 +++
 rtl/dm_access_ctrl_lane_unit.sv | 41 ++++
 rtl/dm_access_ctrl.sv | 117 +++++++++++
 tb/tb_dm_access_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dm_access_ctrl_pkg.sv
// Shared codes for the DM access controller: access sizes, FSM states and the
// request legality check applied at accept time.
package dm_access_ctrl_pkg;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_ILL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } dm_state_t;

  // Misaligned, illegal size, or beyond the end of DM.
  function automatic logic access_err(input logic [31:0] addr,
                                      input logic [1:0]  size,
                                      input int unsigned depth);
    logic [31:0] limit;
    limit = 32'(depth * 4);
    return (size == SZ_ILL) ||
           ((size == SZ_H) && addr[0]) ||
           ((size == SZ_W) && (addr[1:0] != 2'b00)) ||
           (addr >= limit);
  endfunction

endpackage

// File: rtl/dm_access_ctrl_lane_unit.sv
// Little-endian lane steering: merges sub-word store data into a DM word and
// extracts/extends the addressed lane for loads.
module dm_lane_unit
  import dm_access_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] load_val
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[8*addr +: 8];
    half_sel = word[16*addr[1] +: 16];
  end

  always_comb begin
    merged = word;
    case (size)
      SZ_B:    merged[8*addr +: 8]       = wdata[7:0];
      SZ_H:    merged[16*addr[1] +: 16]  = wdata[15:0];
      default: merged = wdata;
    endcase
  end

  always_comb begin
    load_val = word;
    case (size)
      SZ_B:    load_val = {{24{sext & byte_sel[7]}}, byte_sel};
      SZ_H:    load_val = {{16{sext & half_sel[15]}}, half_sel};
      default: load_val = word;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Initiator side of the DM port: turns byte/half/word CPU accesses into
// word-only DM reads/writes, using read-modify-write for sub-word stores.
//   state | meaning
//   IDLE  | ready, waiting for req
//   RD    | DM word read, captured at end of cycle
//   WR    | single DM write cycle
//   DONE  | completion pulse, err=0
//   ERR   | completion pulse, err=1, DM untouched
module dm_access_ctrl
  import dm_access_ctrl_pkg::*;
#(
  parameter int unsigned DM_DEPTH = 3072
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        dm_wr,
  output logic [31:0] dm_a,
  output logic [31:0] dm_wd,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rd
);

  dm_state_t   state, state_nx;
  logic        we_q, sext_q;
  logic [1:0]  size_q, lane_q;
  logic [31:0] wdata_q;
  logic        accept, req_bad;
  logic [31:0] merged, load_val;

  assign accept  = req && (state == ST_IDLE);
  assign req_bad = access_err(addr, size, DM_DEPTH);

  dm_lane_unit u_lane (
    .word     (dm_rd),
    .addr     (lane_q),
    .size     (size_q),
    .sext     (sext_q),
    .wdata    (wdata_q),
    .merged   (merged),
    .load_val (load_val)
  );

  always_ff @(posedge CLK) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (req_bad)                 state_nx = ST_ERR;
          else if (we && size == SZ_W) state_nx = ST_WR;
          else                         state_nx = ST_RD;
        end
      end
      ST_RD:   state_nx = we_q ? ST_WR : ST_DONE;
      ST_WR:   state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      ST_ERR:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = (state == ST_IDLE);
    dm_wr = (state == ST_WR);
    done  = (state == ST_DONE) || (state == ST_ERR);
    err   = (state == ST_ERR);
  end

  // DM-facing registers only move for legal requests, so a rejected access
  // leaves the DM port exactly as it was.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      size_q  <= SZ_B;
      lane_q  <= 2'b00;
      wdata_q <= '0;
      rdata   <= '0;
      dm_a    <= '0;
      dm_wd   <= '0;
      dm_pc   <= '0;
    end else begin
      if (accept) begin
        we_q    <= we;
        sext_q  <= sext;
        size_q  <= size;
        lane_q  <= addr[1:0];
        wdata_q <= wdata;
        if (!req_bad) begin
          dm_a  <= {addr[31:2], 2'b00};
          dm_pc <= pc;
          if (we && size == SZ_W) dm_wd <= wdata;
        end
      end
      if (state == ST_RD) begin
        if (we_q) dm_wd <= merged;
        else      rdata <= load_val;
      end
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl with a word-array DM responder and a
// byte-mask reference model of memory contents, latency and load results.
module tb_dm_access_ctrl;

  localparam int unsigned DEPTH = 3072;
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

  logic        CLK = 1'b0;
  logic        Reset;
  logic        req, we, sext;
  logic [1:0]  size;
  logic [31:0] addr, wdata, pc;
  logic        ready, done, err, dm_wr;
  logic [31:0] rdata, dm_a, dm_wd, dm_pc, dm_rd;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_rdata;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 CLK = ~CLK;

  dm_access_ctrl #(.DM_DEPTH(DEPTH)) dut (
    .CLK(CLK), .Reset(Reset), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .pc(pc), .ready(ready), .done(done), .err(err),
    .rdata(rdata), .dm_wr(dm_wr), .dm_a(dm_a), .dm_wd(dm_wd), .dm_pc(dm_pc),
    .dm_rd(dm_rd)
  );

  // DM responder: combinational read, clocked write, cleared by reset.
  assign dm_rd = (dm_a < LIMIT) ? mem[dm_a[13:2]] : 32'hDEAD_BEEF;

  always @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (dm_wr) begin
      mem[dm_a[13:2]] <= dm_wd;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic m_err(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd3) return 1'b1;
    if (a >= LIMIT) return 1'b1;
    if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_mask(input logic [1:0] sz);
    return (sz == 2'd0) ? 32'h0000_00FF : (sz == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz, input logic sx);
    logic [31:0] v;
    int          bits;
    v = ref_mem[a / 4] >> (8 * (a % 4));
    if (sz == 2'd2) return ref_mem[a / 4];
    bits = (sz == 2'd0) ? 8 : 16;
    v = v & m_mask(sz);
    if (sx && v[bits-1]) v = v | ~m_mask(sz);
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] m;
    int          sh;
    sh = 8 * int'(a % 4);
    m  = m_mask(sz) << sh;
    return (ref_mem[a / 4] & ~m) | ((d << sh) & m);
  endfunction

  task automatic clear_ref();
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
    exp_rdata = '0;
  endtask

  task automatic do_op(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
    logic        e, seen;
    int          lat, n, wrs;
    logic [31:0] pcv, new_word;
    e   = m_err(a, sz);
    lat = e ? 1 : (!w ? 2 : (sz == 2'd2 ? 2 : 3));
    pcv = $urandom;
    new_word = (!e && w) ? m_store(a, sz, d) : 32'h0;
    @(negedge CLK);
    check("ready_idle", 32'(ready), 32'd1);
    req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = d; pc = pcv;
    @(negedge CLK);
    // Inputs after accept must be ignored.
    req = 1'b0; we = ~w; addr = $urandom; wdata = $urandom; pc = $urandom;
    n = 1; seen = 1'b0; wrs = 0;
    while (!seen && n <= 8) begin
      if (dm_wr) begin
        wrs++;
        check("wr_addr", dm_a, {a[31:2], 2'b00});
        check("wr_data", dm_wd, new_word);
        check("wr_pc", dm_pc, pcv);
      end
      if (done) seen = 1'b1;
      else begin
        check("busy_ready", 32'(ready), 32'd0);
        n++;
        @(negedge CLK);
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(n), 32'(lat));
    check("err", 32'(err), 32'(e));
    check("wr_count", 32'(wrs), (!e && w) ? 32'd1 : 32'd0);
    if (!e && w) begin
      ref_mem[a / 4] = new_word;
      check("mem_word", mem[a[13:2]], ref_mem[a / 4]);
    end
    if (!e && !w) exp_rdata = m_load(a, sz, sx);
    check("rdata", rdata, exp_rdata);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          wr_cnt, dn_cnt;
    Reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; sext = 1'b0;
    addr = '0; wdata = '0; pc = '0;
    clear_ref();
    repeat (2) @(negedge CLK);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_dm_a", dm_a, 32'd0);
    Reset = 1'b0;

    // Word store/load, sub-word stores and signed/unsigned loads
    do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h1234_5678);
    do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    check("t1_lw", rdata, 32'h1234_5678);
    do_op(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AB);
    check("t2_word", mem[4], 32'h1234_AB78);
    do_op(1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
    check("t2_lb", rdata, 32'hFFFF_FFAB);
    do_op(1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
    check("t2_lbu", rdata, 32'h0000_00AB);
    do_op(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_8001);
    check("t3_word", mem[4], 32'h8001_AB78);
    do_op(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
    check("t3_lh", rdata, 32'hFFFF_8001);
    do_op(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    check("t3_lhu", rdata, 32'h0000_8001);

    // Error cases and the top-of-DM boundary
    do_op(1'b0, 2'd2, 1'b0, 32'h13, 32'h0);
    do_op(1'b1, 2'd1, 1'b0, 32'h11, 32'hFFFF);
    do_op(1'b1, 2'd2, 1'b0, 32'h3000, 32'hCAFE_F00D);
    do_op(1'b1, 2'd3, 1'b0, 32'h14, 32'h5555_5555);
    check("t4_rdata_kept", rdata, 32'h0000_8001);
    do_op(1'b1, 2'd2, 1'b0, 32'h2FFC, 32'hA5A5_0FF0);
    do_op(1'b0, 2'd0, 1'b1, 32'h2FFF, 32'h0);

    // Reset during the WR cycle of a byte store
    @(negedge CLK);
    req = 1'b1; we = 1'b1; size = 2'd0; sext = 1'b0; addr = 32'h12; wdata = 32'h77; pc = 32'h400;
    @(negedge CLK);
    req = 1'b0;
    @(negedge CLK);
    check("t5_in_wr", 32'(dm_wr), 32'd1);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    clear_ref();
    check("t5_ready", 32'(ready), 32'd1);
    check("t5_done", 32'(done), 32'd0);
    check("t5_err", 32'(err), 32'd0);
    check("t5_rdata", rdata, 32'd0);
    check("t5_dm_wr", 32'(dm_wr), 32'd0);
    check("t5_dm_a", dm_a, 32'd0);
    check("t5_dm_wd", dm_wd, 32'd0);
    check("t5_dm_pc", dm_pc, 32'd0);
    @(negedge CLK);
    check("t5_no_done", 32'(done), 32'd0);
    do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    check("t5_lw_zero", rdata, 32'd0);

    // req held high across two word stores
    @(negedge CLK);
    req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h20; wdata = 32'h1111_2222; pc = 32'h80;
    wr_cnt = 0; dn_cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge CLK);
      if (dm_wr) wr_cnt++;
      if (done) dn_cnt++;
      check("b2b_ready", 32'(ready), (i == 3) ? 32'd1 : 32'd0);
      if (i == 2) begin addr = 32'h24; wdata = 32'h3333_4444; end
      if (i == 4) req = 1'b0;
    end
    ref_mem[8] = 32'h1111_2222;
    ref_mem[9] = 32'h3333_4444;
    check("b2b_wr_pulses", 32'(wr_cnt), 32'd2);
    check("b2b_done_pulses", 32'(dn_cnt), 32'd2);
    check("b2b_mem0", mem[8], ref_mem[8]);
    check("b2b_mem1", mem[9], ref_mem[9]);

    // Random mix against the reference model
    for (int k = 0; k < 80; k++) begin
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) < 8) a = 32'($urandom_range(0, 63));
      else                          a = 32'h2FF8 + 32'($urandom_range(0, 15));
      do_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
